// File: rtl/prog_loader.sv
// Boot loader: receives a framed program image over a byte stream, writes it into
// instruction memory while holding the core in reset, then releases and starts the core.
module prog_loader #(
  parameter int          ADDRESS_BITS = 20,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic                    imem_we,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]   imem_wdata,
  output logic                    core_reset,
  output logic                    start,
  output logic [ADDRESS_BITS-1:0] prog_address,
  output logic                    busy,
  output logic                    error,
  output logic [2:0]              dbg_state
);

  // Handshake: a byte transfers on a rising clock edge where rx_valid && rx_ready;
  // rx_ready depends only on the state, never on rx_valid.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    CHECK = 3'd4,
    START = 3'd5,
    RUN   = 3'd6
  } state_t;

  state_t                  state, state_d;
  logic                    acc;
  logic                    hdr;
  logic [1:0]              byte_cnt;
  logic [23:0]             addr_sh;
  logic [7:0]              count_lo;
  logic [15:0]             words_left;
  logic [23:0]             word_sh;
  logic [7:0]              xor_acc;
  logic [ADDRESS_BITS-1:0] base_addr;
  logic [ADDRESS_BITS-1:0] cur_addr;
  logic [31:0]             addr_full;
  logic [15:0]             count_full;

  assign acc        = rx_valid && rx_ready;
  assign hdr        = (rx_data == HEADER);
  assign addr_full  = {rx_data, addr_sh};
  assign count_full = {rx_data, count_lo};

  assign rx_ready   = (state != START);
  assign core_reset = !((state == START) || (state == RUN));
  assign start      = (state == START);
  assign busy       = (state == ADDR) || (state == COUNT) || (state == DATA) || (state == CHECK);
  assign dbg_state  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (acc && hdr) state_d = ADDR;
      ADDR:    if (acc && byte_cnt == 2'd3) state_d = COUNT;
      COUNT:   if (acc && byte_cnt == 2'd1) state_d = (count_full == 16'd0) ? CHECK : DATA;
      DATA:    if (acc && byte_cnt == 2'd3 && words_left == 16'd1) state_d = CHECK;
      CHECK:   if (acc) state_d = (rx_data == xor_acc) ? START : IDLE;
      START:   state_d = RUN;
      RUN:     if (acc && hdr) state_d = ADDR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt     <= '0;
      addr_sh      <= '0;
      count_lo     <= '0;
      words_left   <= '0;
      word_sh      <= '0;
      xor_acc      <= '0;
      base_addr    <= '0;
      cur_addr     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      prog_address <= '0;
      error        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (acc) begin
        unique case (state)
          IDLE, RUN: if (hdr) begin
            error    <= 1'b0;
            xor_acc  <= '0;
            byte_cnt <= '0;
          end
          ADDR: begin
            addr_sh  <= addr_full[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            // Upper address bits are dropped and the base is forced word-aligned.
            if (byte_cnt == 2'd3) begin
              base_addr <= {addr_full[ADDRESS_BITS-1:2], 2'b00};
              cur_addr  <= {addr_full[ADDRESS_BITS-1:2], 2'b00};
            end
          end
          COUNT: begin
            count_lo <= rx_data;
            if (byte_cnt == 2'd1) begin
              words_left <= count_full;
              byte_cnt   <= '0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
          DATA: begin
            word_sh  <= {rx_data, word_sh[23:8]};
            xor_acc  <= xor_acc ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= cur_addr;
              imem_wdata <= {rx_data, word_sh};
              cur_addr   <= cur_addr + ADDRESS_BITS'(4);
              words_left <= words_left - 16'd1;
            end
          end
          CHECK: begin
            if (rx_data == xor_acc) prog_address <= base_addr;
            else                    error        <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are built by tasks that push expected
// writes/starts to queues; a negedge monitor pops and compares them.
module tb_prog_loader;
  localparam int AB = 20;
  localparam logic [7:0] HDR = 8'hA5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, imem_we, core_reset, start, busy, error;
  logic [AB-1:0] imem_addr, prog_address;
  logic [31:0]   imem_wdata;
  logic [2:0]    dbg_state;

  prog_loader #(.ADDRESS_BITS(AB), .DATA_WIDTH(32), .HEADER(HDR)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .start(start),
    .prog_address(prog_address), .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int last_we = -100;
  int last_gap = 0;
  logic [AB+31:0] exp_q[$];
  logic [AB-1:0]  exp_start_q[$];
  logic [AB+31:0] e_wr;
  logic [AB-1:0]  e_st;
  logic [31:0]    words[0:15];

  always @(posedge clock) cycle++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {12'b0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        e_wr = exp_q.pop_front();
        check("write_addr", {12'b0, imem_addr}, {12'b0, e_wr[AB+31:32]});
        check("write_data", imem_wdata, e_wr[31:0]);
      end
      check("write_spacing", 32'((cycle - last_we) >= 4), 32'd1);
      last_gap = cycle - last_we;
      last_we  = cycle;
    end
    if (!reset && start === 1'b1) begin
      if (exp_start_q.size() == 0) begin
        check("unexpected_start", {12'b0, prog_address}, 32'hFFFF_FFFF);
      end else begin
        e_st = exp_start_q.pop_front();
        check("start_prog_address", {12'b0, prog_address}, {12'b0, e_st});
        check("start_core_reset", {31'b0, core_reset}, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    int t;
    g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    rx_valid = 1'b0;
    repeat (g) begin @(posedge clock); #1; end
    t = 0;
    while (rx_ready !== 1'b1 && t < 8) begin @(posedge clock); #1; t++; end
    if (t == 8) check("rx_ready_timeout", 32'd0, 32'd1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base, input int n, input logic [7:0] cs_flip,
                            input int max_gap);
    logic [7:0]    xr;
    logic [AB-1:0] a_eff;
    logic [AB-1:0] a;
    logic [15:0]   n16;
    xr    = 8'h00;
    a_eff = {base[AB-1:2], 2'b00};
    n16   = 16'(n);
    send_byte(HDR, max_gap);
    check("hdr_error_cleared", {31'b0, error}, 32'd0);
    check("hdr_busy", {31'b0, busy}, 32'd1);
    check("hdr_core_reset", {31'b0, core_reset}, 32'd1);
    for (int i = 0; i < 4; i++) send_byte(base[8*i +: 8], max_gap);
    send_byte(n16[7:0], max_gap);
    send_byte(n16[15:8], max_gap);
    for (int w = 0; w < n; w++) begin
      a = a_eff + AB'(4 * w);
      exp_q.push_back({a, words[w]});
      for (int b = 0; b < 4; b++) begin
        xr = xr ^ words[w][8*b +: 8];
        send_byte(words[w][8*b +: 8], max_gap);
      end
    end
    if (cs_flip == 8'h00) exp_start_q.push_back(a_eff);
    send_byte(xr ^ cs_flip, max_gap);
    if (cs_flip == 8'h00) begin
      check("start_after_checksum", {31'b0, start}, 32'd1);
      check("core_reset_at_start", {31'b0, core_reset}, 32'd0);
      check("rx_ready_at_start", {31'b0, rx_ready}, 32'd0);
    end else begin
      check("error_after_bad_cs", {31'b0, error}, 32'd1);
      check("core_reset_after_bad_cs", {31'b0, core_reset}, 32'd1);
      check("no_start_bad_cs", {31'b0, start}, 32'd0);
      check("busy_after_bad_cs", {31'b0, busy}, 32'd0);
    end
    @(posedge clock); #1;
    check("start_one_cycle", {31'b0, start}, 32'd0);
    check("core_reset_after", {31'b0, core_reset}, (cs_flip == 8'h00) ? 32'd0 : 32'd1);
    check("writes_drained", exp_q.size(), 32'd0);
    check("starts_drained", exp_start_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd1);
    check({tag, "_imem_we"}, {31'b0, imem_we}, 32'd0);
    check({tag, "_imem_addr"}, {12'b0, imem_addr}, 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_core_reset"}, {31'b0, core_reset}, 32'd1);
    check({tag, "_start"}, {31'b0, start}, 32'd0);
    check({tag, "_prog_address"}, {12'b0, prog_address}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_error"}, {31'b0, error}, 32'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Back-to-back 3-word frame at 0
    words[0] = 32'h0000_0013; words[1] = 32'h0010_0093; words[2] = 32'h0000_0013;
    send_frame(32'h0000_0000, 3, 8'h00, 0);
    check("b2b_write_gap", last_gap, 32'd4);
    check("run_core_reset", {31'b0, core_reset}, 32'd0);

    // New frame from RUN: HEADER reasserts core_reset, then start with new base
    words[0] = 32'hDEAD_BEEF;
    send_frame(32'h0000_2000, 1, 8'h00, 0);

    // Bad checksum (entered from RUN)
    words[0] = 32'h0000_0013; words[1] = 32'h0010_0093; words[2] = 32'h0000_0013;
    send_frame(32'h0000_0000, 3, 8'h01, 0);

    // Address wrap; upper bits dropped; HEADER value inside the address is payload
    words[0] = 32'h1111_2222; words[1] = 32'hA5A5_A5A5;
    send_frame(32'hA50F_FFFC, 2, 8'h00, 0);

    // N = 0 good (unaligned base forced to word alignment), then N = 0 bad
    send_frame(32'h0000_0102, 0, 8'h00, 0);
    send_frame(32'h0000_0300, 0, 8'h5A, 0);

    // 16 words back-to-back, then the same image with random valid gaps
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    send_frame(32'h0000_1000, 16, 8'h00, 0);
    send_frame(32'h0000_1000, 16, 8'h00, 3);

    // Reset after 2 data bytes of a 1-word frame
    send_byte(HDR, 0);
    send_byte(8'h40, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    #2 reset = 1'b1;
    #1;
    check_reset_values("midframe_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("after_reset_no_write", exp_q.size(), 32'd0);
    words[0] = 32'hCAFE_F00D;
    send_frame(32'h0000_0040, 1, 8'h00, 0);

    repeat (4) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    check("global_timeout", 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
